piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word through a valid/ready load port and shifts it out one bit per accepted serial beat.
- It is the transmit end of the bit-serial link whose receive end is the team's enable-gated capture register/shift-in chain.
- Used in basic_logic pattern tests as a stateful, handshaked counterpart to the plain D flip-flop capture.

Parameters:
- WIDTH, 8, word width in bits; legal range >= 1.
- MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  reset, asynchronous and active-high; asserting it immediately forces the reset state.
- load_valid  in  1  upstream offers load_data.
- load_ready  out  1  block can accept a word this cycle.
- load_data  in  WIDTH  parallel word; sampled only on load handshake.
- ser_valid  out  1  ser_data holds a valid bit.
- ser_ready  in  1  downstream accepts the current bit.
- ser_data  out  1  current serial bit.
- ser_last  out  1  current bit is the final bit of the word.
- busy  out  1  a word is in flight (state == SHIFT).

Behaviour:
- Reset values: state IDLE; shift register 0; bit counter 0; ser_valid 0; ser_data 0; ser_last 0; busy 0; load_ready 1 (it is combinational in IDLE).
- Reset asserted mid-word: the word is dropped. Outputs take reset values asynchronously. After reset release, no residual bits are sent.
- States:
  - IDLE: no word held.
  - SHIFT: word held, bits being offered.
- Load handshake: load_fire = load_valid && load_ready.
- load_ready = (state == IDLE) || (ser_valid && ser_ready && ser_last). This allows back-to-back words with zero bubble.
- Serial handshake: ser_fire = ser_valid && ser_ready.
- ser_valid = (state == SHIFT).
- ser_data = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
- ser_last = (state == SHIFT) && (cnt == WIDTH-1).
- IDLE transitions:
  - load_fire -> SHIFT, shreg <= load_data, cnt <= 0.
  - Otherwise hold.
- SHIFT transitions:
  - ser_fire && !ser_last: shift shreg by 1 toward the output end, zero fill; cnt <= cnt+1.
  - ser_fire && ser_last && load_fire: stay in SHIFT, shreg <= new load_data, cnt <= 0.
  - ser_fire && ser_last && !load_fire: go to IDLE, shreg <= 0, cnt <= 0.
  - !ser_fire: hold all state; ser_data and ser_last stable (required stall behaviour).
- load_valid while SHIFT and not on the last-bit fire: ignored, load_ready = 0, no state change.
- Latency: the first bit appears on ser_data in the cycle after load_fire. A word occupies exactly WIDTH ser_fire beats.
- Counter width: CNT_W = max(1, $clog2(WIDTH)). For WIDTH=1 every bit is last, and load_ready tracks ser_ready while in SHIFT.
- ser_valid must never drop while ser_ready is low, i.e. no retraction before the handshake completes.
- load_data X while load_valid = 0 must not propagate into state.

Decomposition:
- Shared package basic_logic_pkg:
  - state enum typedef (IDLE, SHIFT);
  - function cnt_width(WIDTH) returning max(1, $clog2(WIDTH)).
- Sub-module: shift_reg_core. It holds the WIDTH-bit register with parallel load, shift enable, direction parameter and async active-high reset. piso_serializer holds the FSM, counter and handshake logic.

Test Plan:
- WIDTH=8, MSB_FIRST=1, ser_ready=1, load 8'hA5 -> ser_data = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; ser_last only on the 8th; then IDLE, busy=0.
- Same word with ser_ready low for 3 cycles after bit 2 -> ser_data=1 (bit 2) and ser_valid held stable for 3 cycles; total 11 cycles; sequence unchanged.
- Back-to-back: load 8'hA5, hold load_valid with 8'h3C -> load_ready high only on the A5 last-bit cycle; the stream continues directly with 0,0,1,1,1,1,0,0; zero idle cycles between words.
- MSB_FIRST=0, load 8'h01 -> first bit 1, then seven 0s; ser_last on the 8th.
- Assert rst after 4 bits of 8'hFF -> ser_valid=0, busy=0, load_ready=1 immediately, without waiting for a clock edge. After release with no load, ser_valid stays 0.
- WIDTH=1, load 1'b1 then 1'b0 back-to-back with ser_ready=1 -> ser_data 1 then 0; ser_last=1 on both; load_ready high each cycle.

Source files
------------

// File: rtl/basic_logic_pkg.sv
// Shared types and helpers for the basic_logic serial link blocks.
// Holds the transmitter FSM state type and counter sizing.
package basic_logic_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_core.sv
// WIDTH-bit register with parallel load, clear and single-step shift.
// Shifts toward the output end selected by MSB_FIRST, zero filling.
module shift_reg_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             out_bit
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (clear) begin
      shreg_d = '0;
    end else if (load_en) begin
      shreg_d = load_data;
    end else if (shift_en) begin
      shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign q       = shreg_q;
  assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready on both sides.
// The last-bit beat may accept the next word for gapless streaming.
import basic_logic_pkg::*;

module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             ser_fire;
  logic             load_fire;
  logic             load_en;
  logic             shift_en;
  logic             clear;
  logic [WIDTH-1:0] shreg;
  logic             out_bit;

  assign ser_valid  = (state_q == SHIFT);
  assign ser_last   = ser_valid && (cnt_q == CNT_LAST);
  assign ser_fire   = ser_valid && ser_ready;
  assign load_ready = !ser_valid || (ser_fire && ser_last);
  assign load_fire  = load_valid && load_ready;
  assign ser_data   = out_bit;
  assign busy       = ser_valid;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    clear    = 1'b0;
    // A new word wins over the end-of-word clear on the last beat.
    if (load_fire) begin
      state_d = SHIFT;
      cnt_d   = '0;
      load_en = 1'b1;
    end else if (ser_fire) begin
      if (ser_last) begin
        state_d = IDLE;
        cnt_d   = '0;
        clear   = 1'b1;
      end else begin
        cnt_d    = cnt_q + CNT_W'(1);
        shift_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  shift_reg_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .load_data(load_data),
    .shift_en (shift_en),
    .clear    (clear),
    .q        (shreg),
    .out_bit  (out_bit)
  );

  logic unused_shreg;
  assign unused_shreg = ^shreg;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three configurations
// (8/MSB, 8/LSB, 1-bit) checked against a per-word bit queue model.
module tb_piso_serializer;

  localparam int W   [3] = '{8, 8, 1};
  localparam bit MSB [3] = '{1'b1, 1'b0, 1'b1};

  typedef struct packed {
    logic d;
    logic l;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] lv;
  logic [2:0] srdy;
  logic [7:0] ld [3];

  logic lr_0, lr_1, lr_2;
  logic sv_0, sv_1, sv_2;
  logic sd_0, sd_1, sd_2;
  logic sl_0, sl_1, sl_2;
  logic bz_0, bz_1, bz_2;

  logic [2:0] lr, sv, sd, sl, bz;
  assign lr = {lr_2, lr_1, lr_0};
  assign sv = {sv_2, sv_1, sv_0};
  assign sd = {sd_2, sd_1, sd_0};
  assign sl = {sl_2, sl_1, sl_0};
  assign bz = {bz_2, bz_1, bz_0};

  exp_t q [3][$];
  int   n_checks;
  int   n_pass;
  bit   ldone;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst),
    .load_valid(lv[0]), .load_ready(lr_0), .load_data(ld[0]),
    .ser_valid(sv_0), .ser_ready(srdy[0]), .ser_data(sd_0),
    .ser_last(sl_0), .busy(bz_0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst),
    .load_valid(lv[1]), .load_ready(lr_1), .load_data(ld[1]),
    .ser_valid(sv_1), .ser_ready(srdy[1]), .ser_data(sd_1),
    .ser_last(sl_1), .busy(bz_1)
  );

  piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_dut2 (
    .clk(clk), .rst(rst),
    .load_valid(lv[2]), .load_ready(lr_2), .load_data(ld[2][0:0]),
    .ser_valid(sv_2), .ser_ready(srdy[2]), .ser_data(sd_2),
    .ser_last(sl_2), .busy(bz_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k,
                     input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d t=%0t: got %b want %b",
                  nm, k, $time, act, exp);
  endtask

  // Monitor: the model is "a queue of bits still owed downstream".
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        q[k].delete();
        chk("rst_ser_valid", k, sv[k], 1'b0);
        chk("rst_load_ready", k, lr[k], 1'b1);
        chk("rst_busy", k, bz[k], 1'b0);
        chk("rst_ser_data", k, sd[k], 1'b0);
        chk("rst_ser_last", k, sl[k], 1'b0);
      end else begin
        logic exp_rdy;
        exp_rdy = (q[k].size() == 0) ||
                  (srdy[k] && q[k].size() == 1);
        chk("load_ready", k, lr[k], exp_rdy);
        chk("ser_valid", k, sv[k], q[k].size() != 0);
        chk("busy", k, bz[k], q[k].size() != 0);
        if (q[k].size() != 0) begin
          chk("ser_data", k, sd[k], q[k][0].d);
          chk("ser_last", k, sl[k], q[k][0].l);
          if (srdy[k]) void'(q[k].pop_front());
        end
        if (lv[k] && exp_rdy) begin
          for (int i = 0; i < W[k]; i++) begin
            exp_t e;
            e.d = MSB[k] ? ld[k][W[k]-1-i] : ld[k][i];
            e.l = (i == W[k] - 1);
            q[k].push_back(e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int k, input logic [7:0] w);
    bit got;
    got = 1'b0;
    lv[k] = 1'b1;
    ld[k] = w;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (lr[k]) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    lv[k] = 1'b0;
    ld[k] = 8'hxx;
    if (!got) chk("load_timeout", k, 1'b0, 1'b1);
  endtask

  task automatic rand_test(input int k, input int nwords);
    ldone = 1'b0;
    fork
      begin
        for (int n = 0; n < nwords; n++) begin
          repeat ($urandom_range(0, 2)) step();
          load_word(k, 8'($urandom));
        end
        ldone = 1'b1;
      end
      begin
        for (int c = 0; c < 3000 && !ldone; c++) begin
          srdy[k] = ($urandom_range(0, 3) != 0);
          step();
        end
        if (!ldone) chk("rand_timeout", k, 1'b0, 1'b1);
      end
    join
    srdy[k] = 1'b1;
    repeat (12) step();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    lv       = '0;
    srdy     = '1;
    for (int k = 0; k < 3; k++) ld[k] = 8'h00;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Plain word, then the same word with a 3-cycle stall after bit 2.
    load_word(0, 8'hA5);
    repeat (10) step();
    load_word(0, 8'hA5);
    step();
    step();
    srdy[0] = 1'b0;
    repeat (3) step();
    srdy[0] = 1'b1;
    repeat (10) step();

    // Back-to-back words with no idle beat between them.
    load_word(0, 8'hA5);
    load_word(0, 8'h3C);
    repeat (10) step();

    // LSB-first instance.
    load_word(1, 8'h01);
    repeat (10) step();

    // Mid-word async reset.
    load_word(0, 8'hFF);
    repeat (4) step();
    #1;
    rst = 1'b1;
    #1;
    chk("async_ser_valid", 0, sv[0], 1'b0);
    chk("async_busy", 0, bz[0], 1'b0);
    chk("async_load_ready", 0, lr[0], 1'b1);
    q[0].delete();
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();

    // One-bit instance, back-to-back.
    load_word(2, 8'h01);
    load_word(2, 8'h00);
    repeat (4) step();

    rand_test(0, 25);
    rand_test(1, 25);
    rand_test(2, 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
